// File: rtl/bch_enc_3_order_seq_if.sv
// Handshake/bus bundle for the bit-serial BCH(1023,993) encoder.
// BCH_ENC_SHORT_EN adds the shortened-code length input.
interface bch_enc_3_order_seq_if;
    logic in_ctr_start;
    logic in_ctr_en;
    logic in_msg_bit;
`ifdef BCH_ENC_SHORT_EN
    localparam int unsigned LEN_W = 10;
    logic [LEN_W-1:0] in_msg_len;
`endif
    logic out_code_bit;
    logic out_code_valid;
    logic out_msg_phase;
    logic out_busy;
    logic out_done;

    modport master (
`ifdef BCH_ENC_SHORT_EN
        output in_msg_len,
`endif
        output in_ctr_start, in_ctr_en, in_msg_bit,
        input  out_code_bit, out_code_valid, out_msg_phase, out_busy, out_done
    );

    modport slave (
`ifdef BCH_ENC_SHORT_EN
        input  in_msg_len,
`endif
        input  in_ctr_start, in_ctr_en, in_msg_bit,
        output out_code_bit, out_code_valid, out_msg_phase, out_busy, out_done
    );
endinterface

// File: rtl/bch_enc_3_order_seq.sv
// Bit-serial systematic BCH(1023,993) t=3 encoder: message pass-through then 30 parity bits.
// Optional macro BCH_ENC_SHORT_EN enables a per-codeword shortened message length.
module bch_enc_3_order_seq #(
    parameter int unsigned GF_LEN  = 10,
    parameter int unsigned MSG_LEN = 993,
    parameter int unsigned PAR_LEN = 30
) (
    input logic                  clk,
    input logic                  in_ctr_Arst_n,
    bch_enc_3_order_seq_if.slave bus
);
    localparam int unsigned       IW       = $clog2(GF_LEN + 1);
    localparam logic [GF_LEN-1:0] PRIM_LOW = GF_LEN'(10'h009);
    localparam logic [GF_LEN-1:0] MSG_LAST = GF_LEN'(MSG_LEN - 1);
    localparam logic [GF_LEN-1:0] PAR_LAST = GF_LEN'(PAR_LEN - 1);

    // GF(2^10) multiply modulo p(x) = x^10 + x^3 + 1
    function automatic logic [GF_LEN-1:0] gf_mul(input logic [GF_LEN-1:0] a,
                                                 input logic [GF_LEN-1:0] b);
        logic [GF_LEN-1:0] p;
        logic [GF_LEN-1:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < GF_LEN; i++) begin
            if (b[IW'(i)]) p = p ^ x;
            x = {x[GF_LEN-2:0], 1'b0} ^ (x[GF_LEN-1] ? PRIM_LOW : '0);
        end
        return p;
    endfunction

    // Minimal polynomial of alpha^e as the product of (x + beta) over its conjugates
    function automatic logic [GF_LEN:0] min_poly(input int unsigned e);
        logic [GF_LEN:0][GF_LEN-1:0] c;
        logic [GF_LEN-1:0]           b;
        logic [GF_LEN:0]             m;
        b = GF_LEN'(1);
        for (int unsigned i = 0; i < e; i++) b = gf_mul(b, GF_LEN'(2));
        c    = '0;
        c[0] = GF_LEN'(1);
        for (int unsigned j = 0; j < GF_LEN; j++) begin
            for (int unsigned k = GF_LEN; k > 0; k--)
                c[IW'(k)] = c[IW'(k - 1)] ^ gf_mul(c[IW'(k)], b);
            c[0] = gf_mul(c[0], b);
            b    = gf_mul(b, b);
        end
        for (int unsigned k = 0; k <= GF_LEN; k++) m[IW'(k)] = c[IW'(k)][0];
        return m;
    endfunction

    function automatic logic [PAR_LEN:0] poly_mul(input logic [PAR_LEN:0] a,
                                                  input logic [GF_LEN:0]  b);
        logic [PAR_LEN:0] p;
        p = '0;
        for (int unsigned i = 0; i <= GF_LEN; i++)
            if (b[IW'(i)]) p = p ^ (a << i);
        return p;
    endfunction

    // g(x) = m1 * m3 * m5; the x^30 term stays implicit in the LFSR
    localparam logic [PAR_LEN:0]   G_FULL   = poly_mul(poly_mul((PAR_LEN + 1)'(min_poly(1)),
                                                                min_poly(3)), min_poly(5));
    localparam logic [PAR_LEN-1:0] GEN_POLY = G_FULL[PAR_LEN-1:0];

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t             state_q, state_d;
    logic [PAR_LEN-1:0] r_q, r_d;
    logic [GF_LEN-1:0]  cnt_q, cnt_d;
    logic [GF_LEN-1:0]  msg_last;
    logic               fin_q, fin_d;
    logic               fb;
    logic               code_bit_d, code_valid_d, msg_phase_d, busy_d, done_d;

`ifdef BCH_ENC_SHORT_EN
    logic [GF_LEN-1:0] msg_last_q, msg_last_d;
    assign msg_last = msg_last_q;
`else
    assign msg_last = MSG_LAST;
`endif

    // Next-state, parity LFSR and output staging
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        cnt_d        = cnt_q;
        fin_d        = 1'b0;
        code_bit_d   = 1'b0;
        code_valid_d = 1'b0;
        msg_phase_d  = 1'b0;
        done_d       = fin_q;
        fb           = bus.in_msg_bit ^ r_q[PAR_LEN-1];
`ifdef BCH_ENC_SHORT_EN
        msg_last_d   = msg_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_ctr_start) begin
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = MSG;
`ifdef BCH_ENC_SHORT_EN
                    if (bus.in_msg_len == '0 || bus.in_msg_len > GF_LEN'(MSG_LEN))
                        msg_last_d = MSG_LAST;
                    else
                        msg_last_d = bus.in_msg_len - GF_LEN'(1);
`endif
                end
            end
            MSG: begin
                if (bus.in_ctr_en) begin
                    r_d          = {r_q[PAR_LEN-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
                    code_bit_d   = bus.in_msg_bit;
                    code_valid_d = 1'b1;
                    msg_phase_d  = 1'b1;
                    cnt_d        = cnt_q + GF_LEN'(1);
                    if (cnt_q == msg_last) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (bus.in_ctr_en) begin
                    r_d          = r_q << 1;
                    code_bit_d   = r_q[PAR_LEN-1];
                    code_valid_d = 1'b1;
                    cnt_d        = cnt_q + GF_LEN'(1);
                    if (cnt_q == PAR_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // busy stays up through the cycle between the last parity bit and done
        busy_d = (state_d != IDLE) || fin_d;
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state_q            <= IDLE;
            r_q                <= '0;
            cnt_q              <= '0;
            fin_q              <= 1'b0;
            bus.out_code_bit   <= 1'b0;
            bus.out_code_valid <= 1'b0;
            bus.out_msg_phase  <= 1'b0;
            bus.out_busy       <= 1'b0;
            bus.out_done       <= 1'b0;
`ifdef BCH_ENC_SHORT_EN
            msg_last_q         <= MSG_LAST;
`endif
        end else begin
            state_q            <= state_d;
            r_q                <= r_d;
            cnt_q              <= cnt_d;
            fin_q              <= fin_d;
            bus.out_code_bit   <= code_bit_d;
            bus.out_code_valid <= code_valid_d;
            bus.out_msg_phase  <= msg_phase_d;
            bus.out_busy       <= busy_d;
            bus.out_done       <= done_d;
`ifdef BCH_ENC_SHORT_EN
            msg_last_q         <= msg_last_d;
`endif
        end
    end
endmodule

// File: tb/tb_bch_enc_3_order_seq.sv
// Scoreboard bench for bch_enc_3_order_seq: long-division parity reference plus S1/S3/S5 syndrome checks.
module tb_bch_enc_3_order_seq;
    localparam int unsigned GF_LEN  = 10;
    localparam int unsigned MSG_LEN = 993;
    localparam int unsigned PAR_LEN = 30;
    localparam int unsigned N_LEN   = MSG_LEN + PAR_LEN;

    typedef struct packed {
        logic b;
        logic phase;
    } exp_t;

    logic clk = 1'b0;
    logic in_ctr_Arst_n;

    bch_enc_3_order_seq_if bus ();

    bch_enc_3_order_seq #(
        .GF_LEN (GF_LEN),
        .MSG_LEN(MSG_LEN),
        .PAR_LEN(PAR_LEN)
    ) dut (
        .clk          (clk),
        .in_ctr_Arst_n(in_ctr_Arst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [9:0]  alog [0:1022];
    logic [30:0] g_full;
    logic        msg [0:N_LEN-1];
    logic        exp_par [0:PAR_LEN-1];
    logic        cw [0:N_LEN-1];
    int          cap_idx = 0;
    int          vcount = 0;
    logic        done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [9:0] gmul(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] p;
        logic [9:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 10; i++) begin
            if (b[i]) p = p ^ x;
            x = x[9] ? ({x[8:0], 1'b0} ^ 10'h009) : {x[8:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [30:0] pmul(input logic [30:0] a, input logic [10:0] b);
        logic [30:0] p;
        p = '0;
        for (int i = 0; i < 11; i++)
            if (b[i]) p = p ^ (a << i);
        return p;
    endfunction

    // Antilog table, then g(x) from brute-force root search of every monic degree-10 polynomial
    task automatic build_ref();
        logic [9:0]  beta;
        logic [9:0]  acc;
        logic [9:0]  fv;
        logic [10:0] mp;
        alog[0] = 10'd1;
        for (int k = 1; k < 1023; k++) alog[k] = gmul(alog[k-1], 10'd2);
        g_full = 31'd1;
        for (int t = 0; t < 3; t++) begin
            beta = alog[2 * t + 1];
            mp   = '0;
            for (int f = 0; f < 1024; f++) begin
                fv  = 10'(f);
                acc = 10'd1;
                for (int k = 9; k >= 0; k--) acc = gmul(acc, beta) ^ {9'd0, fv[k]};
                if (acc == 10'd0 && mp == 11'd0) mp = {1'b1, fv};
            end
            g_full = pmul(g_full, mp);
        end
    endtask

    // Remainder of x^30 * m(x) by g(x), highest degree first
    task automatic compute_parity(input int len);
        logic d [0:N_LEN-1];
        for (int j = 0; j < len + 30; j++) d[j] = (j < len) ? msg[j] : 1'b0;
        for (int j = 0; j < len; j++)
            if (d[j])
                for (int k = 0; k <= 30; k++) d[j+k] = d[j+k] ^ g_full[30-k];
        for (int i = 0; i < 30; i++) exp_par[i] = d[len+i];
    endtask

    function automatic logic [29:0] syndromes(input logic v [0:N_LEN-1], input int n);
        logic [9:0] s1, s3, s5;
        int p;
        s1 = '0; s3 = '0; s5 = '0;
        for (int j = 0; j < n; j++) begin
            if (v[j]) begin
                p  = n - 1 - j;
                s1 = s1 ^ alog[p % 1023];
                s3 = s3 ^ alog[(3 * p) % 1023];
                s5 = s5 ^ alog[(5 * p) % 1023];
            end
        end
        return {s5, s3, s1};
    endfunction

    always @(negedge clk) begin
        if (in_ctr_Arst_n) begin
            if (bus.out_done) check("done_pulse_width", 64'(done_prev), 64'd0);
            done_prev <= bus.out_done;
            if (bus.out_code_valid) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("code_bit", 64'(bus.out_code_bit), 64'(mon_e.b));
                    check("msg_phase", 64'(bus.out_msg_phase), 64'(mon_e.phase));
                end
                if (cap_idx < N_LEN) cw[cap_idx] = bus.out_code_bit;
                cap_idx++;
                vcount++;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code_bit"}, 64'(bus.out_code_bit), 64'd0);
        check({tag, "_valid"},    64'(bus.out_code_valid), 64'd0);
        check({tag, "_phase"},    64'(bus.out_msg_phase), 64'd0);
        check({tag, "_busy"},     64'(bus.out_busy), 64'd0);
        check({tag, "_done"},     64'(bus.out_done), 64'd0);
    endtask

    task automatic run_word(input int len, input bit rand_en, input bit poke,
                            input int abort_at, input string tag);
        int   issued;
        int   cyc;
        int   last_en_cyc;
        logic en;
        issued = 0; cyc = 0; last_en_cyc = 0;
        compute_parity(len);
        cap_idx = 0;
        vcount  = 0;
        bus.in_ctr_start = 1'b1;
        bus.in_ctr_en    = 1'($urandom_range(0, 1));
`ifdef BCH_ENC_SHORT_EN
        bus.in_msg_len   = 10'(len);
`endif
        @(posedge clk); #1;
        bus.in_ctr_start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(bus.out_busy), 64'd1);
        while (issued < len + 30) begin
            en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_ctr_en    = en;
            bus.in_ctr_start = poke && (issued == 100 || issued == len + 5);
            bus.in_msg_bit   = 1'($urandom_range(0, 1));
            if (en) begin
                if (issued < len) begin
                    bus.in_msg_bit = msg[issued];
                    sb.push_back(exp_t'{msg[issued], 1'b1});
                end else begin
                    sb.push_back(exp_t'{exp_par[issued-len], 1'b0});
                end
                issued++;
            end
            @(posedge clk); #1;
            cyc++;
            if (en) last_en_cyc = cyc;
            if (abort_at != 0 && issued == abort_at) begin
                in_ctr_Arst_n    = 1'b0;
                bus.in_ctr_en    = 1'b0;
                bus.in_ctr_start = 1'b0;
                #1;
                check_outputs_zero({tag, "_in_reset"});
                repeat (2) @(posedge clk);
                #1;
                check_outputs_zero({tag, "_held_reset"});
                sb.delete();
                in_ctr_Arst_n = 1'b1;
                return;
            end
        end
        bus.in_ctr_en    = 1'b0;
        bus.in_ctr_start = 1'b0;
        check({tag, "_busy_before_done"}, 64'(bus.out_busy), 64'd1);
        while (!bus.out_done && cyc < last_en_cyc + 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_latency"}, 64'(cyc - last_en_cyc), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus.out_busy), 64'd0);
        if (!rand_en) check({tag, "_start_to_done"}, 64'(cyc), 64'(len + 31));
        check({tag, "_valid_count"}, 64'(vcount), 64'(len + 30));
        check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        check({tag, "_syndrome"}, 64'(syndromes(cw, len + 30)), 64'd0);
    endtask

    task automatic flip_check(input int n, input int nflip);
        logic v [0:N_LEN-1];
        int   pos [3];
        v = cw;
        pos[0] = $urandom_range(0, n - 1);
        for (int i = 1; i < 3; i++) begin
            do pos[i] = $urandom_range(0, n - 1);
            while (pos[i] == pos[0] || (i == 2 && pos[i] == pos[1]));
        end
        for (int i = 0; i < nflip; i++) v[pos[i]] = ~v[pos[i]];
        check("flip_syndrome_nonzero", 64'(syndromes(v, n) != 30'd0), 64'd1);
    endtask

    task automatic random_msg();
        for (int j = 0; j < N_LEN; j++) msg[j] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        in_ctr_Arst_n    = 1'b0;
        bus.in_ctr_start = 1'b0;
        bus.in_ctr_en    = 1'b0;
        bus.in_msg_bit   = 1'b0;
`ifdef BCH_ENC_SHORT_EN
        bus.in_msg_len   = 10'd0;
`endif
        build_ref();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        in_ctr_Arst_n = 1'b1;
        // enable without start must do nothing in IDLE
        bus.in_ctr_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_en_valid", 64'(bus.out_code_valid), 64'd0);
        check("idle_en_busy", 64'(bus.out_busy), 64'd0);

        for (int j = 0; j < N_LEN; j++) msg[j] = 1'b0;
        run_word(MSG_LEN, 1'b0, 1'b0, 0, "zero");

        msg[MSG_LEN-1] = 1'b1;
        run_word(MSG_LEN, 1'b0, 1'b0, 0, "one");
        flip_check(N_LEN, 1);

        for (int w = 0; w < 10; w++) begin
            random_msg();
            run_word(MSG_LEN, 1'b0, 1'b0, 0, "rand");
            flip_check(N_LEN, 1 + (w % 3));
        end

        // same message again with 50% enable and stray start pulses
        run_word(MSG_LEN, 1'b1, 1'b1, 0, "rand_en");

        random_msg();
        run_word(MSG_LEN, 1'b0, 1'b0, 500, "abort");
        run_word(MSG_LEN, 1'b0, 1'b0, 0, "after_reset");

`ifdef BCH_ENC_SHORT_EN
        for (int j = 0; j < N_LEN; j++) msg[j] = 1'b0;
        msg[9] = 1'b1;
        run_word(10, 1'b0, 1'b0, 0, "short");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
